// File: rtl/train_track_pkg.sv
// Shared types and encodings for the two-train, three-track plant model.
`default_nettype none

package train_track_pkg;

  typedef enum logic [1:0] {
    LOOP     = 2'd0,
    SHARED   = 2'd1,
    DERAILED = 2'd2
  } seg_t;

  typedef enum logic {
    TRAIN_A = 1'b0,
    TRAIN_B = 1'b1
  } train_id_t;

  localparam logic [1:0] DRV_FWD = 2'b01;
  localparam logic [1:0] DRV_REV = 2'b10;

  // Switch values that route train A; train B uses the inverted value.
  localparam logic SW1_A = 1'b0;
  localparam logic SW2_A = 1'b0;

endpackage

`default_nettype wire

// File: rtl/train_track_plant_train.sv
// One train: segment/position state, exit pulse and derail detection.
`default_nettype none

module track_plant_train
  import train_track_pkg::*;
#(
  parameter int        LOOP_LEN   = 8,
  parameter int        SHARED_LEN = 6,
  parameter int        POS_W      = 3,
  parameter int        INIT       = 0,
  parameter train_id_t ID         = TRAIN_A
) (
  input  logic             Clock,
  input  logic             reset,
  input  logic             tick,
  input  logic [1:0]       drive,
  input  logic             sw1,
  input  logic             sw2,
  input  logic             sw3,
  output seg_t             seg,
  output logic [POS_W-1:0] pos,
  output logic             exit_pulse,
  output logic             derailed
);

  localparam logic [POS_W-1:0] LOOP_END   = POS_W'(LOOP_LEN - 1);
  localparam logic [POS_W-1:0] SHARED_END = POS_W'(SHARED_LEN - 1);
  localparam logic [POS_W-1:0] INIT_POS   = POS_W'(INIT);
  localparam logic             SW1_SEL    = (ID == TRAIN_A) ? SW1_A : ~SW1_A;
  localparam logic             SW2_SEL    = (ID == TRAIN_A) ? SW2_A : ~SW2_A;

  seg_t             seg_next;
  logic [POS_W-1:0] pos_next;
  logic             exit_next;

  always_comb begin
    seg_next  = seg;
    pos_next  = pos;
    exit_next = 1'b0;
    // The spur diverter wrecks a train on shared immediately, tick or not.
    if (seg == SHARED && sw3) begin
      seg_next = DERAILED;
    end else if (tick && seg != DERAILED) begin
      case (drive)
        DRV_FWD: begin
          if (seg == LOOP) begin
            if (pos < LOOP_END) begin
              pos_next = pos + 1'b1;
            end else if (sw1 == SW1_SEL) begin
              seg_next = SHARED;
              pos_next = '0;
            end else begin
              seg_next = DERAILED;
            end
          end else begin
            if (pos < SHARED_END) begin
              pos_next = pos + 1'b1;
            end else if (sw2 == SW2_SEL) begin
              seg_next  = LOOP;
              pos_next  = '0;
              exit_next = 1'b1;
            end else begin
              seg_next = DERAILED;
            end
          end
        end
        DRV_REV: begin
          if (pos != '0) pos_next = pos - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (reset) begin
      seg        <= LOOP;
      pos        <= INIT_POS;
      exit_pulse <= 1'b0;
    end else begin
      seg        <= seg_next;
      pos        <= pos_next;
      exit_pulse <= exit_next;
    end
  end

  // Derailed is terminal until reset, so the segment itself is the sticky flag.
  assign derailed = (seg == DERAILED);

endmodule

`default_nettype wire

// File: rtl/train_track_plant.sv
// Plant model for the two-train layout: prescaler, both trains and sensor decode.
`default_nettype none

module train_track_plant
  import train_track_pkg::*;
#(
  parameter int LOOP_LEN   = 8,
  parameter int SHARED_LEN = 6,
  parameter int TICK_DIV   = 4,
  parameter int A_INIT     = 0,
  parameter int B_INIT     = 0
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic       SW1,
  input  logic       SW2,
  input  logic       SW3,
  input  logic       DA1,
  input  logic       DA0,
  input  logic       DB1,
  input  logic       DB0,
  output logic       S1,
  output logic       S2,
  output logic       S3,
  output logic       S4,
  output logic       S5,
  output logic       collision,
  output logic       derail,
  output logic [1:0] a_seg,
  output logic [1:0] b_seg
);

  localparam int POS_W = $clog2((LOOP_LEN > SHARED_LEN) ? LOOP_LEN : SHARED_LEN);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TICK_DIV - 1);
  localparam logic [POS_W-1:0] LOOP_END   = POS_W'(LOOP_LEN - 1);
  localparam logic [POS_W-1:0] SHARED_MID = POS_W'(SHARED_LEN / 2);

  logic [CNT_W-1:0] count;
  logic             tick;
  seg_t             seg_a, seg_b;
  logic [POS_W-1:0] pos_a, pos_b;
  logic             exit_a, exit_b;
  logic             derail_a, derail_b;
  logic             both_shared;
  logic             collided;

  assign tick = (count == CNT_LAST);

  always_ff @(posedge Clock) begin
    if (reset || tick) count <= '0;
    else               count <= count + 1'b1;
  end

  track_plant_train #(
    .LOOP_LEN(LOOP_LEN), .SHARED_LEN(SHARED_LEN), .POS_W(POS_W),
    .INIT(A_INIT), .ID(TRAIN_A)
  ) u_train_a (
    .Clock(Clock), .reset(reset), .tick(tick), .drive({DA1, DA0}),
    .sw1(SW1), .sw2(SW2), .sw3(SW3),
    .seg(seg_a), .pos(pos_a), .exit_pulse(exit_a), .derailed(derail_a)
  );

  track_plant_train #(
    .LOOP_LEN(LOOP_LEN), .SHARED_LEN(SHARED_LEN), .POS_W(POS_W),
    .INIT(B_INIT), .ID(TRAIN_B)
  ) u_train_b (
    .Clock(Clock), .reset(reset), .tick(tick), .drive({DB1, DB0}),
    .sw1(SW1), .sw2(SW2), .sw3(SW3),
    .seg(seg_b), .pos(pos_b), .exit_pulse(exit_b), .derailed(derail_b)
  );

  assign both_shared = (seg_a == SHARED) && (seg_b == SHARED);

  // Registered sticky bit plus the live condition so the flag shows on the same edge.
  always_ff @(posedge Clock) begin
    if (reset)            collided <= 1'b0;
    else if (both_shared) collided <= 1'b1;
  end

  assign collision = collided | both_shared;
  assign derail    = derail_a | derail_b;

  assign S1 = (seg_a == LOOP) && (pos_a == LOOP_END);
  assign S2 = (seg_b == LOOP) && (pos_b == LOOP_END);
  assign S3 = exit_b;
  assign S4 = exit_a;
  assign S5 = ((seg_a == SHARED) && (pos_a == SHARED_MID)) ||
              ((seg_b == SHARED) && (pos_b == SHARED_MID));

  assign a_seg = seg_a;
  assign b_seg = seg_b;

endmodule

`default_nettype wire

// File: tb/tb_train_track_plant.sv
// Directed vector bench for train_track_plant with default parameters.
`default_nettype none

module tb_train_track_plant;

  logic       Clock = 1'b0;
  logic       reset = 1'b1;
  logic       SW1 = 1'b0, SW2 = 1'b0, SW3 = 1'b0;
  logic [1:0] da = 2'b00, db = 2'b00;
  logic       S1, S2, S3, S4, S5, collision, derail;
  logic [1:0] a_seg, b_seg;

  int n_checks = 0;
  int n_fail   = 0;

  train_track_plant dut (
    .Clock(Clock), .reset(reset),
    .SW1(SW1), .SW2(SW2), .SW3(SW3),
    .DA1(da[1]), .DA0(da[0]), .DB1(db[1]), .DB0(db[0]),
    .S1(S1), .S2(S2), .S3(S3), .S4(S4), .S5(S5),
    .collision(collision), .derail(derail), .a_seg(a_seg), .b_seg(b_seg)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string       name;
    logic        rst;
    logic        sw1, sw2, sw3;
    logic [1:0]  da, db;
    int          n;
    logic [10:0] exp;   // {S1,S2,S3,S4,S5}_{collision,derail}_{a_seg}_{b_seg}
  } vec_t;

  vec_t vecs[$];

  function automatic logic [10:0] obs();
    return {S1, S2, S3, S4, S5, collision, derail, a_seg, b_seg};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic rst, input logic sw1, input logic sw2,
                     input logic sw3, input logic [1:0] a, input logic [1:0] b,
                     input int n, input logic [10:0] exp);
    vec_t v;
    v.name = name; v.rst = rst; v.sw1 = sw1; v.sw2 = sw2; v.sw3 = sw3;
    v.da = a; v.db = b; v.n = n; v.exp = exp;
    vecs.push_back(v);
  endtask

  localparam logic [10:0] ZERO = 11'b00000_00_00_00;

  int cyc;
  int s3_cnt, s4_cnt;

  initial begin
    // A alone, SW1 favours B: reaches junction at edge 28, derails at 32
    add("reset_a",     1, 0, 0, 0, 2'b00, 2'b00, 1,  ZERO);
    add("a_pos6",      0, 1, 0, 0, 2'b01, 2'b00, 27, ZERO);
    add("a_s1",        0, 1, 0, 0, 2'b01, 2'b00, 1,  11'b10000_00_00_00);
    add("a_s1_hold",   0, 1, 0, 0, 2'b01, 2'b00, 3,  11'b10000_00_00_00);
    add("a_derail",    0, 1, 0, 0, 2'b01, 2'b00, 1,  11'b00000_01_10_00);
    // A lap through shared and back to loop 1
    add("reset_sh",    1, 0, 0, 0, 2'b00, 2'b00, 1,  ZERO);
    add("sh_s1",       0, 0, 0, 0, 2'b01, 2'b00, 28, 11'b10000_00_00_00);
    add("sh_enter",    0, 0, 0, 0, 2'b01, 2'b00, 4,  11'b00000_00_01_00);
    add("sh_pos2",     0, 0, 0, 0, 2'b01, 2'b00, 11, 11'b00000_00_01_00);
    add("sh_s5",       0, 0, 0, 0, 2'b01, 2'b00, 1,  11'b00001_00_01_00);
    add("sh_pos4",     0, 0, 0, 0, 2'b01, 2'b00, 4,  11'b00000_00_01_00);
    add("sh_pos5",     0, 0, 0, 0, 2'b01, 2'b00, 7,  11'b00000_00_01_00);
    add("sh_s4",       0, 0, 0, 0, 2'b01, 2'b00, 1,  11'b00010_00_00_00);
    add("sh_s4_end",   0, 0, 0, 0, 2'b01, 2'b00, 1,  ZERO);
    // B lap
    add("reset_b",     1, 0, 0, 0, 2'b00, 2'b00, 1,  ZERO);
    add("b_s2",        0, 1, 1, 0, 2'b00, 2'b01, 28, 11'b01000_00_00_00);
    add("b_enter",     0, 1, 1, 0, 2'b00, 2'b01, 4,  11'b00000_00_00_01);
    add("b_s3",        0, 1, 1, 0, 2'b00, 2'b01, 24, 11'b00100_00_00_00);
    add("b_s3_end",    0, 1, 1, 0, 2'b00, 2'b01, 1,  ZERO);
    // Simultaneous junction arrival: SW1 admits A, B derails
    add("reset_sim",   1, 0, 0, 0, 2'b00, 2'b00, 1,  ZERO);
    add("sim_junc",    0, 0, 0, 0, 2'b01, 2'b01, 28, 11'b11000_00_00_00);
    add("sim_arrive",  0, 0, 0, 0, 2'b01, 2'b01, 4,  11'b00000_01_01_10);
    // Spur diverter while A on shared, then mid-run reset
    add("reset_sw3",   1, 0, 0, 0, 2'b00, 2'b00, 1,  ZERO);
    add("sw3_pre",     0, 0, 0, 0, 2'b01, 2'b00, 40, 11'b00000_00_01_00);
    add("sw3_derail",  0, 0, 0, 1, 2'b01, 2'b00, 1,  11'b00000_01_10_00);
    add("reset_mid",   1, 0, 0, 1, 2'b01, 2'b00, 1,  ZERO);
    add("post_reset",  0, 0, 0, 0, 2'b00, 2'b00, 4,  ZERO);
    // Reverse saturation and stop codes, observed through S1 timing
    add("reset_rev",   1, 0, 0, 0, 2'b00, 2'b00, 1,  ZERO);
    add("rev_fwd",     0, 0, 0, 0, 2'b01, 2'b00, 4,  ZERO);
    add("rev_back",    0, 0, 0, 0, 2'b10, 2'b00, 4,  ZERO);
    add("rev_sat",     0, 0, 0, 0, 2'b10, 2'b00, 8,  ZERO);
    add("stop11",      0, 0, 0, 0, 2'b11, 2'b00, 8,  ZERO);
    add("stop00",      0, 0, 0, 0, 2'b00, 2'b00, 4,  ZERO);
    add("rev_fwd2",    0, 0, 0, 0, 2'b01, 2'b00, 27, ZERO);
    add("rev_s1",      0, 0, 0, 0, 2'b01, 2'b00, 1,  11'b10000_00_00_00);

    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      SW1 = vecs[i].sw1; SW2 = vecs[i].sw2; SW3 = vecs[i].sw3;
      da = vecs[i].da; db = vecs[i].db;
      step(vecs[i].n);
      check(vecs[i].name, obs(), vecs[i].exp);
    end

    // Collision: B trails A by one tick and follows it onto shared
    reset = 1'b1; SW1 = 1'b0; SW2 = 1'b0; SW3 = 1'b0; da = 2'b00; db = 2'b00;
    step(1);
    reset = 1'b0; da = 2'b01;
    step(4);
    db = 2'b01;
    step(28);
    check("col_b_junc", obs(), 11'b01000_00_01_00);
    SW1 = 1'b1;
    cyc = 0;
    while (!collision && cyc < 40) begin
      step(1);
      cyc++;
    end
    check("col_latency", 11'(cyc), 11'd4);
    check("col_state", obs(), 11'b00000_10_01_01);

    // A exits at edge 56 (one S4 pulse); B reaches the end at 60 and derails on SW2=0
    s3_cnt = 0; s4_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      step(1);
      if (S3) s3_cnt++;
      if (S4) s4_cnt++;
    end
    check("col_s4_width", 11'(s4_cnt), 11'd1);
    check("col_s3_none", 11'(s3_cnt), 11'd0);
    check("col_sticky", obs(), 11'b00000_11_00_10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
